// File: rtl/lstat.sv
// lstat: load-status unit of the ALU program-flow group.
// On a start strobe, the 8-bit processor status register is sampled and
// formatted into a 20-bit write-back word. Each capture produces a
// one-cycle valid pulse one clock later.
// A history copy of the last sampled status is kept for change detection.
//
// Optional feature macro: LSTAT_POPCNT_EN
//   defined   : mode 2 appends a population count to the status byte.
//   undefined : mode 2 formats exactly like mode 0 (raw), and no
//               popcount logic exists.

module lstat (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  status_register,
    input  logic        start,
    input  logic [1:0]  mode,
    output logic [19:0] data_out,
    output logic        valid
);

    // Output format selector, decoded from the mode input.
    typedef enum logic [1:0] {
        MODE_RAW     = 2'd0,
        MODE_SWAP    = 2'd1,
        MODE_POPCNT  = 2'd2,
        MODE_HISTORY = 2'd3
    } mode_e;

    logic [19:0] data_out_q, data_out_d;
    logic        valid_q,    valid_d;
    logic [7:0]  prev_sr_q,  prev_sr_d;

    logic [19:0] formatted;
    logic        sr_changed;

`ifdef LSTAT_POPCNT_EN
    // Count the set bits of a status byte; the result is 0..8, so 4 bits suffice.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, v[i]};
        end
        return cnt;
    endfunction
`endif

    // Format the live status byte according to the requested mode.
    always_comb begin
        formatted  = 20'h00000;
        sr_changed = (prev_sr_q != status_register);
        case (mode_e'(mode))
            MODE_RAW: begin
                formatted = {12'h000, status_register};
            end
            MODE_SWAP: begin
                formatted = {12'h000, status_register[3:0], status_register[7:4]};
            end
`ifdef LSTAT_POPCNT_EN
            MODE_POPCNT: begin
                formatted = {8'h00, status_register, popcount8(status_register)};
            end
`else
            MODE_POPCNT: begin
                formatted = {12'h000, status_register};
            end
`endif
            MODE_HISTORY: begin
                formatted = {prev_sr_q, status_register, 3'b000, sr_changed};
            end
            default: begin
                formatted = {12'h000, status_register};
            end
        endcase
    end

    // Capture a new word on start; otherwise hold the word and history and drop valid.
    always_comb begin
        data_out_d = data_out_q;
        prev_sr_d  = prev_sr_q;
        valid_d    = 1'b0;
        if (start) begin
            data_out_d = formatted;
            prev_sr_d  = status_register;
            valid_d    = 1'b1;
        end
    end

    // State registers; reset clears everything at once, independent of the clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_q <= 20'h00000;
            valid_q    <= 1'b0;
            prev_sr_q  <= 8'h00;
        end else begin
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            prev_sr_q  <= prev_sr_d;
        end
    end

    assign data_out = data_out_q;
    assign valid    = valid_q;

endmodule

// File: tb/tb_lstat.sv
// Scoreboarded testbench for lstat.
// Stimulus pushes the expected word into a queue. A monitor pops the queue and compares
// on every cycle in which valid is high.

module tb_lstat;

   logic        clk;
   logic        rst;
   logic [7:0]  status_register;
   logic        start;
   logic [1:0]  mode;
   logic [19:0] data_out;
   logic        valid;

   int checks;
   int errors;
   logic [19:0] exp_q[$];

   lstat dut (
      .clk             (clk),
      .rst             (rst),
      .status_register (status_register),
      .start           (start),
      .mode            (mode),
      .data_out        (data_out),
      .valid           (valid)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one value and record the outcome.
   task automatic checkOutput(input string name, input logic [19:0] actual, input logic [19:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%05h, expected 0x%05h", name, actual, expected);
      end
   endtask

   // Issue one start at the next falling edge and queue its expected word.
   task automatic applyStimulus(input logic [7:0] sr, input logic [1:0] m, input logic [19:0] expected);
      @(negedge clk);
      status_register = sr;
      mode            = m;
      start           = 1'b1;
      exp_q.push_back(expected);
   endtask

   // Drop start and let a number of cycles pass.
   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   // Pop and compare each presented word; a valid with nothing expected is an error.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_valid: got data 0x%05h, expected no valid pulse", data_out);
            end else begin
               checkOutput("scoreboard_word", data_out, exp_q.pop_front());
            end
         end
      end
   end

   // Bound the whole run so it can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [19:0] pop_exp_ff;
      logic [19:0] pop_exp_5a;
      int          wait_cnt;

`ifdef LSTAT_POPCNT_EN
      pop_exp_ff = 20'h00FF8;
      pop_exp_5a = 20'h005A4;
`else
      pop_exp_ff = 20'h000FF;
      pop_exp_5a = 20'h0005A;
`endif

      checks          = 0;
      errors          = 0;
      rst             = 1'b1;
      start           = 1'b0;
      mode            = 2'd0;
      status_register = 8'h00;

      // Reset, then idle: outputs stay at zero.
      repeat (2) @(negedge clk);
      checkOutput("reset_data", data_out, 20'h00000);
      checkOutput("reset_valid", {19'd0, valid}, 20'h00000);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("idle_data", data_out, 20'h00000);
         checkOutput("idle_valid", {19'd0, valid}, 20'h00000);
      end

      // RAW capture, then input noise without start must not disturb the held word.
      applyStimulus(8'hFF, 2'd0, 20'h000FF);
      @(negedge clk);
      start           = 1'b0;
      status_register = 8'h12;
      mode            = 2'd3;
      idleCycles(2);
      checkOutput("raw_hold_data", data_out, 20'h000FF);
      checkOutput("raw_hold_valid", {19'd0, valid}, 20'h00000);

      // SWAP and POPCNT formats.
      applyStimulus(8'hA5, 2'd1, 20'h0005A);
      idleCycles(2);
      applyStimulus(8'hFF, 2'd2, pop_exp_ff);
      idleCycles(2);
      applyStimulus(8'h5A, 2'd2, pop_exp_5a);
      applyStimulus(8'h5A, 2'd3, 20'h5A5A0);
      idleCycles(2);

      // Back-to-back history sequence.
      applyStimulus(8'hFF, 2'd0, 20'h000FF);
      applyStimulus(8'h0F, 2'd3, 20'hFF0F1);
      applyStimulus(8'h0F, 2'd3, 20'h0F0F0);
      @(negedge clk);
      start = 1'b0;
      checkOutput("b2b_valid_third", {19'd0, valid}, 20'h00001);
      idleCycles(2);
      checkOutput("b2b_hold", data_out, 20'h0F0F0);

      // Reset arriving together with a start: the start is discarded and outputs clear at once.
      @(negedge clk);
      status_register = 8'h3C;
      mode            = 2'd0;
      start           = 1'b1;
      rst             = 1'b1;
      #1;
      checkOutput("async_reset_data", data_out, 20'h00000);
      checkOutput("async_reset_valid", {19'd0, valid}, 20'h00000);
      @(negedge clk);
      start = 1'b0;
      checkOutput("reset_held_data", data_out, 20'h00000);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(8'h3C, 2'd3, 20'h003C1);
      idleCycles(3);

      // Every queued expectation must have been matched by a valid pulse.
      wait_cnt = 0;
      while (exp_q.size() != 0 && wait_cnt < 20) begin
         @(negedge clk);
         wait_cnt++;
      end
      checkOutput("scoreboard_drained", 20'(exp_q.size()), 20'h00000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
